// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory store path: buffered entry layout, drain FSM states, default depth.
package mips_mem_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } sb_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular store FIFO holding {word address, data}; exposes all slots plus pointer/count for matching.
// Latency: push/pop take effect on the next rising edge; contents visible combinationally.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
module sb_fifo import mips_mem_pkg::*; #(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push,
    input  sb_entry_t                            push_entry,
    input  logic                                 pop,
    output sb_entry_t [DEPTH-1:0]                entries,
    output logic      [$clog2(DEPTH)-1:0]        rd_ptr,
    output logic      [$clog2(DEPTH):0]          count,
    output logic                                 full,
    output logic                                 empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t [DEPTH-1:0] store_q;
    logic      [PW-1:0]    wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign entries = store_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Slot contents are only meaningful inside the count window, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) store_q[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between M stage and data memory; STORE_BUFFER_FWD_EN enables store-to-load forwarding.
// Latency: store accepted on the edge, write request one cycle after the buffer becomes non-empty.
// Backpressure: stallM on store while full; without forwarding also stalls on an address match.
module store_buffer import mips_mem_pkg::*; #(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wreq,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    input  logic        mem_wack
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    drain_state_t          state;
    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t             new_entry;
    sb_entry_t             oldest;
    logic      [PW-1:0]    rd_ptr;
    logic      [PW-1:0]    idx;
    logic      [CW-1:0]    sb_count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  hit;
    logic                  drain_last;
`ifdef STORE_BUFFER_FWD_EN
    logic      [31:0]      fwd_data;
`endif

    assign new_entry = '{addr: aluoutM[31:2], data: writedataM};
    assign push      = memwriteM & ~stallM;
    assign pop       = mem_wreq & mem_wack;
    assign oldest    = entries[rd_ptr];

    assign mem_raddr = aluoutM;
    assign mem_wreq  = (state == REQ);
    assign mem_waddr = {oldest.addr, 2'b00};
    assign mem_wdata = oldest.data;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (new_entry),
        .pop        (pop),
        .entries    (entries),
        .rd_ptr     (rd_ptr),
        .count      (sb_count),
        .full       (full),
        .empty      (empty)
    );

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        hit = 1'b0;
        idx = '0;
`ifdef STORE_BUFFER_FWD_EN
        fwd_data = mem_rdata;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < sb_count) && (entries[idx].addr == aluoutM[31:2])) begin
                hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                fwd_data = entries[idx].data;
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign readdataM = hit ? fwd_data : mem_rdata;
    assign stallM    = memwriteM & full;
`else
    // A store never waits on a match: FIFO order already keeps same-address stores ordered.
    assign readdataM = mem_rdata;
    assign stallM    = memwriteM ? full : hit;
`endif

    assign drain_last = pop && (sb_count == CW'(1)) && !push;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (!empty)     state <= REQ;
                REQ:     if (drain_last) state <= IDLE;
                default:                 state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: accepted stores queued, compared as memory writes complete.
module tb_store_buffer;

    localparam int          DEPTH     = 4;
    localparam logic [31:0] IDLE_ADDR = 32'h0000_F000;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wreq;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wack;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    st_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
    endfunction

    assign mem_rdata = mem_val(mem_raddr);

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_wreq   (mem_wreq),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wack   (mem_wack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: checks at the falling edge, scoreboard updates, then returns #1 after the rising edge.
    task automatic step();
        bit          hit;
        bit          exp_stall;
        bit          acc;
        logic [31:0] fwd;
        @(negedge clk);
        if (reset) begin
            hit = 1'b0;
            fwd = mem_val(aluoutM);
            foreach (sb_q[i]) begin
                if (sb_q[i].addr[31:2] == aluoutM[31:2]) begin
                    hit = 1'b1;
                    fwd = sb_q[i].data;
                end
            end
`ifdef STORE_BUFFER_FWD_EN
            exp_stall = memwriteM && (sb_q.size() == DEPTH);
            if (!memwriteM) chk("readdata", readdataM, fwd);
`else
            exp_stall = memwriteM ? (sb_q.size() == DEPTH) : hit;
            chk("readdata", readdataM, mem_val(aluoutM));
`endif
            chk("stall", {31'b0, stallM}, {31'b0, exp_stall});
            acc = memwriteM && !exp_stall;
            if (mem_wreq && mem_wack) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_wr", {31'b0, mem_wreq}, 32'd0);
                end else begin
                    chk("waddr", mem_waddr, {sb_q[0].addr[31:2], 2'b00});
                    chk("wdata", mem_wdata, sb_q[0].data);
                    void'(sb_q.pop_front());
                end
            end
            if (acc) sb_q.push_back('{addr: aluoutM, data: writedataM});
        end
        @(posedge clk);
        #1;
        if (!reset) sb_q.delete();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwriteM  = 1'b1;
        aluoutM    = a;
        writedataM = d;
        step();
        memwriteM  = 1'b0;
        aluoutM    = IDLE_ADDR;
    endtask

    task automatic drain();
        mem_wack = 1'b1;
        for (int i = 0; i < 40 && (sb_q.size() != 0 || mem_wreq); i++) step();
        chk("drain_pending", sb_q.size(), 32'd0);
        chk("drain_wreq", {31'b0, mem_wreq}, 32'd0);
        chk("drain_count", {29'b0, dut.sb_count}, 32'd0);
        mem_wack = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        memwriteM  = 1'b0;
        aluoutM    = IDLE_ADDR;
        writedataM = '0;
        mem_wack   = 1'b0;
        step();
        step();
        chk("rst_wreq", {31'b0, mem_wreq}, 32'd0);
        chk("rst_stall", {31'b0, stallM}, 32'd0);
        chk("rst_count", {29'b0, dut.sb_count}, 32'd0);
        chk("rst_rdata", readdataM, mem_val(IDLE_ADDR));
        reset = 1'b1;
        step();

        // Single store with memory always ready
        mem_wack = 1'b1;
        store(32'h0000_0100, 32'hDEAD_BEEF);
        chk("single_wreq_pre", {31'b0, mem_wreq}, 32'd0);
        step();
        chk("single_wreq", {31'b0, mem_wreq}, 32'd1);
        chk("single_waddr", mem_waddr, 32'h0000_0100);
        chk("single_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        chk("single_empty", {29'b0, dut.sb_count}, 32'd0);
        chk("single_wreq_off", {31'b0, mem_wreq}, 32'd0);
        mem_wack = 1'b0;
        step();

        // Fill to full, fifth store stalls until one entry drains
        for (int i = 0; i < 4; i++) store(32'h0000_0200 + 32'(4 * i), 32'(i + 1));
        memwriteM  = 1'b1;
        aluoutM    = 32'h0000_0210;
        writedataM = 32'd5;
        #1;
        chk("full_stall", {31'b0, stallM}, 32'd1);
        mem_wack = 1'b1;
        step();
        mem_wack = 1'b0;
        #1;
        chk("full_after_ack", {29'b0, dut.sb_count}, 32'd3);
        chk("full_unstall", {31'b0, stallM}, 32'd0);
        step();
        chk("full_again", {29'b0, dut.sb_count}, 32'd4);
        memwriteM = 1'b0;
        aluoutM   = IDLE_ADDR;
        drain();

        // Two stores to one word, then a load of that word
        store(32'h0000_0040, 32'h0000_0011);
        store(32'h0000_0040, 32'h0000_0022);
        aluoutM = 32'h0000_0042;
        #1;
`ifdef STORE_BUFFER_FWD_EN
        chk("fwd_data", readdataM, 32'h0000_0022);
        chk("fwd_nostall", {31'b0, stallM}, 32'd0);
        aluoutM = 32'h0000_0044;
        #1;
        chk("fwd_miss", readdataM, mem_val(32'h0000_0044));
        aluoutM = IDLE_ADDR;
`else
        chk("hz_stall", {31'b0, stallM}, 32'd1);
        step();
        step();
        chk("hz_stall_hold", {31'b0, stallM}, 32'd1);
        mem_wack = 1'b1;
        step();
        chk("hz_one_left", {29'b0, dut.sb_count}, 32'd1);
        chk("hz_stall_one", {31'b0, stallM}, 32'd1);
        step();
        chk("hz_stall_clr", {31'b0, stallM}, 32'd0);
        chk("hz_rdata", readdataM, mem_val(32'h0000_0042));
        mem_wack = 1'b0;
        aluoutM  = IDLE_ADDR;
`endif
        drain();

        // Simultaneous push and pop
        store(32'h0000_0300, 32'h0000_000A);
        store(32'h0000_0304, 32'h0000_000B);
        step();
        chk("pp_count_pre", {29'b0, dut.sb_count}, 32'd2);
        chk("pp_wreq", {31'b0, mem_wreq}, 32'd1);
        memwriteM  = 1'b1;
        aluoutM    = 32'h0000_0308;
        writedataM = 32'h0000_000C;
        mem_wack   = 1'b1;
        step();
        memwriteM = 1'b0;
        aluoutM   = IDLE_ADDR;
        mem_wack  = 1'b0;
        chk("pp_count", {29'b0, dut.sb_count}, 32'd2);
        chk("pp_waddr", mem_waddr, 32'h0000_0304);
        drain();

        // Reset while draining discards pending stores
        store(32'h0000_0400, 32'h0000_1000);
        store(32'h0000_0404, 32'h0000_1001);
        store(32'h0000_0408, 32'h0000_1002);
        step();
        chk("rd_wreq_pre", {31'b0, mem_wreq}, 32'd1);
        chk("rd_count_pre", {29'b0, dut.sb_count}, 32'd3);
        reset = 1'b0;
        step();
        chk("rd_wreq", {31'b0, mem_wreq}, 32'd0);
        chk("rd_count", {29'b0, dut.sb_count}, 32'd0);
        reset    = 1'b1;
        mem_wack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rd_no_write", {31'b0, mem_wreq}, 32'd0);
        end
        mem_wack = 1'b0;

        // Same-address stores both drain, younger last, with memory always ready
        mem_wack = 1'b1;
        store(32'h0000_0500, 32'h0000_0001);
        store(32'h0000_0500, 32'h0000_0002);
        store(32'h0000_0504, 32'h0000_0003);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores; power of two, minimum 2.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-low (asserted at 0).
REQ-004 SHALL have port memwriteM, input, 1, core store request for the current M-stage instruction.
REQ-005 SHALL have port aluoutM, input, 32, core byte address for load or store.
REQ-006 SHALL have port writedataM, input, 32, core store data.
REQ-007 SHALL have port readdataM, output, 32, load data returned to the core in the same cycle.
REQ-008 SHALL have port stallM, output, 1, to the hazard unit; core holds its M stage while it is 1.
REQ-009 SHALL have port mem_raddr, output, 32, asynchronous-read address to data memory.
REQ-010 SHALL have port mem_rdata, input, 32, asynchronous read data from data memory.
REQ-011 SHALL have port mem_wreq, output, 1, write request to data memory.
REQ-012 SHALL have port mem_waddr, output, 32, write address (word-aligned) held with mem_wreq.
REQ-013 SHALL have port mem_wdata, output, 32, write data held with mem_wreq.
REQ-014 SHALL have port mem_wack, input, 1, memory accepts the presented write in this cycle.

Function
REQ-015 SHALL hold stores in a DEPTH-entry circular FIFO: {word address [31:2], data}, write and read pointers, and a count of log2(DEPTH)+1 bits; pointers wrap from DEPTH-1 to 0.
REQ-016 SHALL push on a rising edge when memwriteM=1 and stallM=0.
REQ-017 SHALL drive stallM = memwriteM & full, combinationally; stallM SHALL NOT depend on mem_wack, and no push SHALL occur while full, even if a pop occurs in the same cycle.
REQ-018 SHALL use a drain FSM with states IDLE and REQ: IDLE->REQ when count>0; REQ->IDLE when mem_wack=1 and count becomes 0; otherwise it remains in REQ.
REQ-019 SHALL drive mem_wreq=1 only in REQ, with mem_waddr={oldest.addr,2'b00} and mem_wdata=oldest.data stable until mem_wack is sampled high.
REQ-020 SHALL pop the oldest entry on the edge where mem_wreq=1 and mem_wack=1; mem_wack while mem_wreq=0 SHALL be ignored.
REQ-021 SHALL, on a simultaneous push and pop when not full, leave count unchanged and advance both pointers.
REQ-022 SHALL drive mem_raddr = aluoutM at all times; aluoutM[1:0] SHALL be ignored for every compare.
REQ-023 SHALL return stores to memory in push order; consecutive stores to the same address both drain, and the younger one is written last.
REQ-024 SHALL, with the empty FIFO, return readdataM = mem_rdata.

Reset
REQ-025 SHALL, while reset=0 at an edge, clear pointers and count, enter IDLE, and discard all pending entries; it is documented data loss.
REQ-026 SHALL produce these outputs during and after reset: mem_wreq=0 from the first edge after reset is sampled low, and stallM=0 while empty.
REQ-027 SHALL have entry storage that needs no reset; no output SHALL depend on invalid entries.

Configuration
REQ-028 SHALL be governed by macro STORE_BUFFER_FWD_EN. When it is defined, readdataM SHALL be the data of the youngest valid entry whose address matches aluoutM[31:2], else mem_rdata.
REQ-029 When STORE_BUFFER_FWD_EN is undefined, readdataM SHALL be mem_rdata, and stallM SHALL also assert whenever any valid entry matches aluoutM[31:2], until that entry drains.

Structure
REQ-030 SHALL place the entry struct typedef, the drain-state enum {IDLE, REQ}, and the DEPTH default in a shared package, mips_mem_pkg.
REQ-031 SHALL implement the FIFO storage and pointers as one sub-module, sb_fifo; the FSM, stall logic and forwarding SHALL stay in store_buffer.

Verification
REQ-032 SHALL cover a single store: a store to 0x100 of 0xDEADBEEF with mem_wack tied to 1 gives mem_wreq=1 with waddr 0x100 one cycle later, and the buffer is empty one cycle after that.
REQ-033 SHALL cover fill to full: 5 stores with mem_wack=0 and DEPTH=4 give stallM=1 on the 5th store; after one ack, the 5th is accepted on the next edge, and the drain order is 1..5.
REQ-034 SHALL cover forwarding (FWD_EN): stores of 0x11 then 0x22 to 0x40, mem_wack=0, then a load of 0x42 gives readdataM=0x22; a load of 0x44 gives mem_rdata.
REQ-035 SHALL cover no forwarding (FWD_EN undefined): the same sequence gives stallM=1 on the load of 0x40 until both entries drain, then readdataM=mem_rdata.
REQ-036 SHALL cover simultaneous push and pop: count=2 with a store and a mem_wack in the same cycle gives count still 2, and the waddr of the next request is the second-oldest address.
REQ-037 SHALL cover reset mid-drain: reset=0 while mem_wreq=1 and count=3 gives mem_wreq=0 and count=0 on the next edge, with no further writes issued.
